// File: rtl/rr_arb_mux_if.sv
// Handshake/bus bundle for rr_arb_mux.
// slave modport is the arbiter side, master modport is the environment side.
// RR_ARB_MUX_LOCK_EN adds the per-channel lock_i request.
interface rr_arb_mux_if #(
  parameter int size  = 32,
  parameter int ch    = 4,
  parameter int sel_w = 2
);
  logic [ch-1:0]      valid_i;
  logic [ch*size-1:0] data_i;
  logic [ch-1:0]      ready_o;
  logic [size-1:0]    data_o;
  logic               valid_o;
  logic               ready_i;
  logic [sel_w-1:0]   grant_idx_o;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [ch-1:0]      lock_i;
`endif

  modport slave (
`ifdef RR_ARB_MUX_LOCK_EN
    input  lock_i,
`endif
    input  valid_i, data_i, ready_i,
    output ready_o, data_o, valid_o, grant_idx_o
  );

  modport master (
`ifdef RR_ARB_MUX_LOCK_EN
    output lock_i,
`endif
    output valid_i, data_i, ready_i,
    input  ready_o, data_o, valid_o, grant_idx_o
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel registered multiplexer with round-robin arbitration.
// One output register slot; a new word is accepted whenever the slot is empty
// or being drained this cycle, giving one word per cycle sustained.
// RR_ARB_MUX_LOCK_EN: a channel holding lock_i keeps the grant while it stays
// valid; the round-robin pointer is frozen for the duration of the lock.
module rr_arb_mux #(
  parameter int size  = 32,
  parameter int ch    = 4,
  parameter int sel_w = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rr_arb_mux_if.slave   bus
);

  logic               valid_q;
  logic [size-1:0]    data_q;
  logic [sel_w-1:0]   grant_q;
  logic [sel_w-1:0]   ptr_q;
  logic [sel_w-1:0]   ptr_d;
  logic               free;
  logic               gnt_found;
  logic [sel_w-1:0]   gnt_idx;
  logic [size-1:0]    gnt_data;

  assign free = !valid_q || bus.ready_i;

`ifdef RR_ARB_MUX_LOCK_EN
  logic held_q;
  logic locked;
  // held_q keeps a stale grant_idx_o after reset from acting as a lock owner
  assign locked = held_q && bus.lock_i[grant_q] && bus.valid_i[grant_q];
`endif

  // Pick the first valid channel after the last grant, wrapping modulo ch
  always_comb begin
    logic [sel_w-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= ch; i++) begin
      cand = sel_w'((int'(ptr_q) + i) % ch);
      if (!gnt_found && bus.valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    ptr_d = gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
    if (locked) begin
      gnt_found = 1'b1;
      gnt_idx   = grant_q;
      ptr_d     = ptr_q;
    end
`endif
  end

  // Steer the granted channel's word toward the output register
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < ch; k++) begin
      if (gnt_idx == sel_w'(k)) gnt_data = bus.data_i[k*size +: size];
    end
  end

  // Accept strobe back to the winning source; silent during reset
  always_comb begin
    bus.ready_o = '0;
    if (rst_i && free && gnt_found) bus.ready_o[gnt_idx] = 1'b1;
  end

  // Output slot: capture on grant, empty on drain, hold under backpressure
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= sel_w'(ch - 1);
    end else if (free) begin
      if (gnt_found) begin
        valid_q <= 1'b1;
        data_q  <= gnt_data;
        grant_q <= gnt_idx;
        ptr_q   <= ptr_d;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Remember that grant_q names a real owner since the last reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 held_q <= 1'b0;
    else if (free && gnt_found) held_q <= 1'b1;
  end
`endif

  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.grant_idx_o = grant_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: directed scenarios plus random traffic,
// checked against a queue-based round-robin reference model.
module tb_rr_arb_mux;
  localparam int CH = 4;
  localparam int SZ = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.size(SZ), .ch(CH), .sel_w(SW)) bus ();

  rr_arb_mux #(.size(SZ), .ch(CH), .sel_w(SW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct { int idx; logic [SZ-1:0] data; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [SZ-1:0] din [CH];
  logic [CH-1:0] lk = '0;

  // reference model state
  int            m_ptr  = CH - 1;
  int            m_cur  = 0;
  logic [SZ-1:0] m_data = '0;
  bit            m_vo   = 1'b0;
  bit            m_held = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: each word taken by the consumer must be the oldest granted word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got word idx %0d with nothing expected", bus.grant_idx_o);
        end else begin
          e = sb.pop_front();
          chk("sb_idx", 64'(bus.grant_idx_o), 64'(e.idx));
          chk("sb_data", 64'(bus.data_o), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One cycle: drive inputs, predict the grant, check at mid-cycle, advance model
  task automatic cycle(input logic [CH-1:0] v, input logic r, input bit rnd,
                       output logic [CH-1:0] ro, output logic vo);
    int            g;
    bit            free;
    bit            locked;
    logic [CH-1:0] er;
    logic [1:0]    c;
    if (rnd) for (int k = 0; k < CH; k++) din[k] = $urandom;
    bus.valid_i = v;
    bus.ready_i = r;
    for (int k = 0; k < CH; k++) bus.data_i[k*SZ +: SZ] = din[k];
`ifdef RR_ARB_MUX_LOCK_EN
    bus.lock_i = lk;
`endif
    free   = !m_vo || r;
    g      = -1;
    locked = 1'b0;
    c      = 2'(m_cur);
`ifdef RR_ARB_MUX_LOCK_EN
    locked = m_held && lk[c] && v[c];
`endif
    if (free) begin
      if (locked) g = m_cur;
      else for (int s = 1; s <= CH; s++) begin
        c = 2'((m_ptr + s) % CH);
        if (g < 0 && v[c]) g = (m_ptr + s) % CH;
      end
    end
    er = '0;
    if (g >= 0) begin
      er[2'(g)] = 1'b1;
      sb.push_back('{g, din[g]});
    end
    @(negedge clk);
    ro = bus.ready_o;
    vo = bus.valid_o;
    chk("ready_o", 64'(ro), 64'(er));
    chk("valid_o", 64'(vo), 64'(m_vo));
    chk("grant_idx_o", 64'(bus.grant_idx_o), 64'(m_cur));
    chk("data_o", 64'(bus.data_o), 64'(m_data));
    if (free) begin
      if (g >= 0) begin
        m_vo = 1'b1; m_cur = g; m_data = din[g]; m_held = 1'b1;
        if (!locked) m_ptr = g;
      end else m_vo = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from any clock edge and hold it for two cycles
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_ready_o", 64'(bus.ready_o), 64'd0);
    sb.delete();
    m_vo = 1'b0; m_ptr = CH - 1; m_cur = 0; m_data = '0; m_held = 1'b0;
    bus.valid_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_hold_data_o", 64'(bus.data_o), 64'd0);
    chk("rst_hold_grant", 64'(bus.grant_idx_o), 64'd0);
    chk("rst_hold_ready_o", 64'(bus.ready_o), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CH-1:0] ro;
    logic [CH-1:0] prev;
    logic          vo;
    int            held;
    bus.valid_i = '1;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
`ifdef RR_ARB_MUX_LOCK_EN
    bus.lock_i  = '0;
`endif
    for (int k = 0; k < CH; k++) din[k] = '0;
    @(posedge clk);
    #1;

    // reset then rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, 1'b1, ro, vo);
      chk("order_after_reset", 64'(ro), 64'(4'b0001 << (i % 4)));
    end

    // lone requester on channel 2
    din[2] = 32'hA5A5_0002;
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0100, 1'b1, 1'b0, ro, vo);
      chk("single_ready", 64'(ro), 64'(4'b0100));
    end
    chk("single_data", 64'(bus.data_o), 64'(32'hA5A5_0002));
    chk("single_idx", 64'(bus.grant_idx_o), 64'd2);

    // backpressure with everyone requesting
    cycle(4'b1111, 1'b1, 1'b1, ro, vo);
    held = m_cur;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0, 1'b1, ro, vo);
      chk("bp_ready_zero", 64'(ro), 64'd0);
    end
    cycle(4'b1111, 1'b1, 1'b1, ro, vo);
    chk("bp_next_grant", 64'(ro), 64'(4'b0001 << ((held + 1) % 4)));

    // back-to-back between channels 0 and 3
    prev = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1001, 1'b1, 1'b1, ro, vo);
      if (i > 0) begin
        chk("b2b_alternate", 64'(ro), 64'(prev == 4'b0001 ? 4'b1000 : 4'b0001));
        chk("b2b_no_bubble", 64'(vo), 64'd1);
      end
      prev = ro;
    end

    // reset while a word is held under backpressure
    cycle(4'b1111, 1'b0, 1'b1, ro, vo);
    chk("midrst_pre_valid", 64'(bus.valid_o), 64'd1);
    bus.ready_i = 1'b0;
    do_reset();
    cycle(4'b0110, 1'b1, 1'b1, ro, vo);
    chk("midrst_first_grant", 64'(ro), 64'(4'b0010));

`ifdef RR_ARB_MUX_LOCK_EN
    do_reset();
    cycle(4'b1111, 1'b1, 1'b1, ro, vo);
    lk = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b1, 1'b1, ro, vo);
      chk("lock_hold", 64'(ro), 64'(4'b0010));
    end
    lk = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b1, 1'b1, ro, vo);
      chk("lock_release", 64'(ro), 64'(4'b0100 << i) | 64'(i == 2 ? 4'b0001 : 4'b0000) & 64'hF);
    end
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
`ifdef RR_ARB_MUX_LOCK_EN
      lk = 4'($urandom);
`endif
      cycle(4'($urandom), $urandom_range(0, 3) != 0, 1'b1, ro, vo);
    end

    chk("sb_leftover", 64'(sb.size()), 64'(m_vo));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
